// File: rtl/output_unit.sv
// Presents a loaded WIDTH-bit value one bit at a time, MSB first, on a single output.
// Bits advance on rising edges of btn_next (STEP_CYCLES==0) or every STEP_CYCLES cycles.
module output_unit #(
  parameter int WIDTH       = 8,
  parameter int STEP_CYCLES = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [WIDTH-1:0]       value,
  input  logic                   value_valid,
  input  logic                   btn_next,
  output logic                   ready,
  output logic                   bit_out,
  output logic                   bit_valid,
  output logic [$clog2(WIDTH):0] bit_idx,
  output logic                   done,
  output logic [WIDTH-1:0]       shown_value
);

  localparam int IW = $clog2(WIDTH) + 1;
  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'((STEP_CYCLES > 0) ? STEP_CYCLES - 1 : 0);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SHOW = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    step_cnt;
  logic             btn_next_d;
  logic             next_rise;
  logic             advance;

  assign ready     = (state == IDLE) & enable;
  assign next_rise = btn_next & ~btn_next_d;

  // Manual mode steps on a fresh press only; auto mode ignores the button entirely.
  always_comb begin
    advance = 1'b0;
    if (STEP_CYCLES == 0)
      advance = next_rise;
    else
      advance = (step_cnt == LAST_CNT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      shreg       <= '0;
      step_cnt    <= '0;
      btn_next_d  <= 1'b0;
      bit_out     <= 1'b0;
      bit_valid   <= 1'b0;
      bit_idx     <= '0;
      done        <= 1'b0;
      shown_value <= '0;
    end else begin
      btn_next_d <= btn_next;
      done       <= 1'b0;
      if (!enable) begin
        state       <= IDLE;
        shreg       <= '0;
        step_cnt    <= '0;
        bit_out     <= 1'b0;
        bit_valid   <= 1'b0;
        bit_idx     <= '0;
        shown_value <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (value_valid) begin
              shreg       <= value;
              shown_value <= value;
              bit_idx     <= '0;
              step_cnt    <= '0;
              bit_valid   <= 1'b1;
              bit_out     <= value[WIDTH-1];
              state       <= SHOW;
            end
          end
          SHOW: begin
            if (advance) begin
              step_cnt <= '0;
              if (bit_idx == LAST_IDX) begin
                done      <= 1'b1;
                bit_valid <= 1'b0;
                bit_out   <= 1'b0;
                bit_idx   <= '0;
                state     <= IDLE;
              end else begin
                shreg   <= shreg << 1;
                bit_out <= shreg[WIDTH-2];
                bit_idx <= bit_idx + 1'b1;
              end
            end else begin
              step_cnt <= step_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_output_unit.sv
// Drives a manual-step and an auto-step (4 cycles/bit) output_unit from shared inputs
// and compares both every cycle against a timeline-style reference model.
module tb_output_unit;
  localparam int W = 8;
  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] value = '0;
  logic       value_valid = 1'b0;
  logic       btn_next = 1'b0;

  logic       m_ready, m_bit_out, m_bit_valid, m_done;
  logic [3:0] m_bit_idx;
  logic [7:0] m_shown;
  logic       a_ready, a_bit_out, a_bit_valid, a_done;
  logic [3:0] a_bit_idx;
  logic [7:0] a_shown;

  int checks = 0;
  int failures = 0;
  bit check_on = 1'b0;

  output_unit #(.WIDTH(W), .STEP_CYCLES(0)) dut_manual (
    .clk(clk), .rst(rst), .enable(enable), .value(value), .value_valid(value_valid),
    .btn_next(btn_next), .ready(m_ready), .bit_out(m_bit_out), .bit_valid(m_bit_valid),
    .bit_idx(m_bit_idx), .done(m_done), .shown_value(m_shown));

  output_unit #(.WIDTH(W), .STEP_CYCLES(S)) dut_auto (
    .clk(clk), .rst(rst), .enable(enable), .value(value), .value_valid(value_valid),
    .btn_next(btn_next), .ready(a_ready), .bit_out(a_bit_out), .bit_valid(a_bit_valid),
    .bit_idx(a_bit_idx), .done(a_done), .shown_value(a_shown));

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference model: manual mode tracks which bit index is on show; auto mode
  // tracks elapsed cycles since load and derives the index by division.
  logic       m_busy, m_prev, m_exp_done;
  logic [7:0] m_val, m_exp_shown;
  int         m_idx;
  logic       a_busy, a_exp_done;
  logic [7:0] a_val, a_exp_shown;
  int         a_t;
  wire        m_rise = btn_next & ~m_prev;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 0; m_prev <= 0; m_exp_done <= 0; m_val <= 0; m_exp_shown <= 0; m_idx <= 0;
      a_busy <= 0; a_exp_done <= 0; a_val <= 0; a_exp_shown <= 0; a_t <= 0;
    end else begin
      m_exp_done <= 0;
      a_exp_done <= 0;
      m_prev <= btn_next;
      if (!enable) begin
        m_busy <= 0; m_idx <= 0; m_exp_shown <= 0;
        a_busy <= 0; a_t <= 0; a_exp_shown <= 0;
      end else begin
        if (!m_busy) begin
          if (value_valid) begin
            m_busy <= 1; m_val <= value; m_exp_shown <= value; m_idx <= 0;
          end
        end else if (m_rise) begin
          if (m_idx == W - 1) begin
            m_busy <= 0; m_idx <= 0; m_exp_done <= 1;
          end else begin
            m_idx <= m_idx + 1;
          end
        end
        if (!a_busy) begin
          if (value_valid) begin
            a_busy <= 1; a_val <= value; a_exp_shown <= value; a_t <= 0;
          end
        end else if (a_t + 1 == W * S) begin
          a_busy <= 0; a_t <= 0; a_exp_done <= 1;
        end else begin
          a_t <= a_t + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_on) begin
      checkOutput("m_ready", 32'(m_ready), 32'(!m_busy && enable));
      checkOutput("m_bit_valid", 32'(m_bit_valid), 32'(m_busy));
      checkOutput("m_bit_out", 32'(m_bit_out), 32'(m_busy ? m_val[W-1-m_idx] : 1'b0));
      checkOutput("m_bit_idx", 32'(m_bit_idx), m_busy ? 32'(m_idx) : 32'd0);
      checkOutput("m_done", 32'(m_done), 32'(m_exp_done));
      checkOutput("m_shown", 32'(m_shown), 32'(m_exp_shown));
      checkOutput("a_ready", 32'(a_ready), 32'(!a_busy && enable));
      checkOutput("a_bit_valid", 32'(a_bit_valid), 32'(a_busy));
      checkOutput("a_bit_out", 32'(a_bit_out), 32'(a_busy ? a_val[W-1-(a_t/S)] : 1'b0));
      checkOutput("a_bit_idx", 32'(a_bit_idx), a_busy ? 32'(a_t / S) : 32'd0);
      checkOutput("a_done", 32'(a_done), 32'(a_exp_done));
      checkOutput("a_shown", 32'(a_shown), 32'(a_exp_shown));
    end
  end

  // Inputs change 2 time units after the rising edge so every edge sees stable values.
  task automatic applyStimulus(input logic en, input logic [7:0] v, input logic vv, input logic btn);
    enable = en; value = v; value_valid = vv; btn_next = btn;
    @(posedge clk);
    #2;
  endtask

  task automatic pressNext();
    applyStimulus(1, 8'h00, 0, 1);
    applyStimulus(1, 8'h00, 0, 0);
  endtask

  task automatic abortBoth();
    applyStimulus(0, 8'h00, 0, 0);
    applyStimulus(1, 8'h00, 0, 0);
  endtask

  logic [7:0] pat;
  bit         got;

  initial begin
    rst = 1'b1;
    applyStimulus(0, 8'h00, 0, 0);
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("reset_bit_valid", 32'(m_bit_valid), 32'd0);
    checkOutput("reset_shown", 32'(a_shown), 32'd0);
    rst = 1'b0;
    check_on = 1'b1;
    applyStimulus(1, 8'h00, 0, 0);
    checkOutput("idle_ready", 32'(m_ready), 32'd1);

    // Manual A5 sequence
    pat = 8'hA5;
    applyStimulus(1, 8'hA5, 1, 0);
    applyStimulus(1, 8'h00, 0, 0);
    checkOutput("a5_bit0", 32'(m_bit_out), 32'd1);
    for (int i = 1; i < 8; i++) begin
      pressNext();
      checkOutput("a5_idx", 32'(m_bit_idx), 32'(i));
      checkOutput("a5_bit", 32'(m_bit_out), 32'(pat[7-i]));
    end
    applyStimulus(1, 8'h00, 0, 1);
    checkOutput("a5_done", 32'(m_done), 32'd1);
    checkOutput("a5_ready", 32'(m_ready), 32'd1);
    applyStimulus(1, 8'h00, 0, 0);
    checkOutput("a5_done_pulse", 32'(m_done), 32'd0);

    // Busy strobe ignored
    abortBoth();
    pat = 8'h3C;
    applyStimulus(1, 8'h3C, 1, 0);
    applyStimulus(1, 8'hFF, 1, 0);
    applyStimulus(1, 8'h00, 0, 0);
    checkOutput("busy_shown", 32'(m_shown), 32'h3C);
    checkOutput("busy_bit0", 32'(m_bit_out), 32'd0);
    for (int i = 1; i < 8; i++) begin
      pressNext();
      checkOutput("busy_bit", 32'(m_bit_out), 32'(pat[7-i]));
    end
    pressNext();
    checkOutput("busy_shown_kept", 32'(m_shown), 32'h3C);

    // Auto mode 81
    abortBoth();
    applyStimulus(1, 8'h81, 1, 0);
    for (int c = 0; c < 32; c++) begin
      checkOutput("auto_valid", 32'(a_bit_valid), 32'd1);
      checkOutput("auto_bit", 32'(a_bit_out), 32'((c < 4 || c >= 28) ? 1 : 0));
      applyStimulus(1, 8'h00, 0, 0);
    end
    checkOutput("auto_done", 32'(a_done), 32'd1);
    checkOutput("auto_valid_end", 32'(a_bit_valid), 32'd0);

    // Held button across load
    abortBoth();
    applyStimulus(1, 8'h55, 1, 1);
    for (int i = 0; i < 5; i++) applyStimulus(1, 8'h00, 0, 1);
    checkOutput("held_idx", 32'(m_bit_idx), 32'd0);
    applyStimulus(1, 8'h00, 0, 0);
    applyStimulus(1, 8'h00, 0, 1);
    checkOutput("held_repress_idx", 32'(m_bit_idx), 32'd1);

    // Abort and restart
    abortBoth();
    applyStimulus(1, 8'hF0, 1, 0);
    for (int i = 0; i < 3; i++) pressNext();
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("abort_valid", 32'(m_bit_valid), 32'd0);
    checkOutput("abort_shown", 32'(m_shown), 32'd0);
    checkOutput("abort_done", 32'(m_done), 32'd0);
    applyStimulus(1, 8'h0F, 1, 0);
    checkOutput("restart_idx", 32'(m_bit_idx), 32'd0);
    checkOutput("restart_shown", 32'(m_shown), 32'h0F);

    // Async reset mid-show at index 5
    for (int i = 0; i < 5; i++) pressNext();
    checkOutput("pre_reset_idx", 32'(m_bit_idx), 32'd5);
    #1 rst = 1'b1;
    #1;
    checkOutput("async_valid", 32'(m_bit_valid), 32'd0);
    checkOutput("async_idx", 32'(m_bit_idx), 32'd0);
    checkOutput("async_shown", 32'(m_shown), 32'd0);
    applyStimulus(1, 8'h00, 0, 0);
    rst = 1'b0;

    // Back-to-back load right after done (auto unit)
    applyStimulus(1, 8'hC3, 1, 0);
    got = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      applyStimulus(1, 8'h00, 0, 0);
      if (a_done) got = 1;
    end
    checkOutput("b2b_done_seen", 32'(got), 32'd1);
    applyStimulus(1, 8'h5A, 1, 0);
    checkOutput("b2b_valid", 32'(a_bit_valid), 32'd1);
    checkOutput("b2b_shown", 32'(a_shown), 32'h5A);

    // Randomized traffic checked every cycle by the model
    for (int n = 0; n < 600; n++) begin
      applyStimulus(($urandom_range(0, 24) != 0), 8'($urandom), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 2) == 0));
      if ($urandom_range(0, 80) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end

    check_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
